// File: rtl/pwm_pkg.sv
// pwm_pkg: shared state/direction types and channel-index width helper for pwm_multichannel
package pwm_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  typedef enum logic {UP, DOWN} dir_t;
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/pwm_prescaler.sv
// pwm_prescaler: reload counter emitting one tick every reload+1 cycles, cleared by clr
module pwm_prescaler #(
  parameter int W = 8
) (
  input  logic         SLK,
  input  logic         RST,
  input  logic         clr,
  input  logic [W-1:0] reload,
  output logic         tick
);
  logic [W-1:0] cnt;
  assign tick = cnt == reload;
  always_ff @(posedge SLK or posedge RST)
    if (RST) cnt <= '0;
    else cnt <= (clr || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/pwm_multichannel.sv
// pwm_multichannel: shared-counter multi-channel PWM with duty/period changes applied at period boundaries.
// Define PWM_CENTER_ALIGN_EN to add the center_mode input and up/down (center-aligned) counting.
module pwm_multichannel
  import pwm_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH = 8,
  parameter int PRESCALE_W = 8,
  localparam int CH_W = ch_w(CHANNELS)
) (
  input  logic                  SLK,
  input  logic                  RST,
  input  logic                  enable,
  input  logic [WIDTH-1:0]      period,
  input  logic [PRESCALE_W-1:0] prescale,
`ifdef PWM_CENTER_ALIGN_EN
  input  logic                  center_mode,
`endif
  input  logic                  wr_valid,
  input  logic [CH_W-1:0]       wr_ch,
  input  logic [WIDTH-1:0]      wr_duty,
  output logic [CHANNELS-1:0]   pwm_out,
  output logic                  period_start,
  output logic                  update_pending,
  output logic                  running
);
  state_t state, state_nx;
  logic [WIDTH-1:0] cnt, cnt_step, act_period, p_last;
  logic [PRESCALE_W-1:0] act_prescale;
  logic [CHANNELS-1:0] cmp, diff;
  logic tick, wrap_up, at_end, load;
  // a zero period behaves as a one-tick period whose outputs stay low
  assign p_last = (act_period == '0) ? '0 : act_period - 1'b1;
  assign wrap_up = cnt == p_last;
`ifdef PWM_CENTER_ALIGN_EN
  logic act_center;
  dir_t dir;
  assign at_end = tick && (act_center ? (dir == DOWN && cnt == '0) : wrap_up);
  assign cnt_step = !act_center ? (wrap_up ? '0 : cnt + 1'b1)
                  : (dir == UP) ? (wrap_up ? cnt : cnt + 1'b1)
                  : (cnt == '0) ? '0 : cnt - 1'b1;
  always_ff @(posedge SLK or posedge RST)
    if (RST) begin
      act_center <= 1'b0;
      dir <= UP;
    end else begin
      if (load) act_center <= center_mode;
      dir <= (load || state == IDLE) ? UP
           : !(tick && act_center) ? dir
           : (dir == UP && wrap_up) ? DOWN
           : (dir == DOWN && cnt == '0) ? UP : dir;
    end
`else
  assign at_end = tick && wrap_up;
  assign cnt_step = wrap_up ? '0 : cnt + 1'b1;
`endif
  // stopping at a period end skips the boundary load and returns straight to IDLE
  always_comb begin
    load = enable && (state == IDLE || at_end);
    state_nx = (state == IDLE || at_end) ? (enable ? RUN : IDLE) : (enable ? RUN : DRAIN);
  end
  always_ff @(posedge SLK or posedge RST)
    if (RST) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge SLK or posedge RST)
    if (RST) begin
      cnt <= '0;
      act_period <= '0;
      act_prescale <= '0;
      period_start <= 1'b0;
      pwm_out <= '0;
    end else begin
      period_start <= load;
      pwm_out <= (state != IDLE && state_nx != IDLE) ? cmp : '0;
      cnt <= (state == IDLE || load) ? '0 : tick ? cnt_step : cnt;
      if (load) begin
        act_period <= period;
        act_prescale <= prescale;
      end
    end
  pwm_prescaler #(.W(PRESCALE_W)) u_prescaler (
    .SLK(SLK),
    .RST(RST),
    .clr(state == IDLE || load),
    .reload(act_prescale),
    .tick(tick)
  );
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] shadow, active;
    always_ff @(posedge SLK or posedge RST)
      if (RST) begin
        shadow <= '0;
        active <= '0;
      end else begin
        if (wr_valid && wr_ch == CH_W'(i)) shadow <= wr_duty;
        if (load) active <= shadow;
      end
    assign cmp[i] = (act_period != '0) && (cnt < active);
    assign diff[i] = shadow != active;
  end
  assign update_pending = |diff;
  assign running = state != IDLE;
endmodule

// File: tb/tb_pwm_multichannel.sv
// tb_pwm_multichannel: directed + randomized checks of pwm_multichannel against an elapsed-time reference model
module tb_pwm_multichannel;
  localparam int CH = 5, W = 8, PW = 8, CW = 3;
  logic clk = 1'b0, rst = 1'b1, enable = 1'b0, wr_valid = 1'b0;
  logic [W-1:0] period = '0, wr_duty = '0;
  logic [PW-1:0] prescale = '0;
  logic [CW-1:0] wr_ch = '0;
`ifdef PWM_CENTER_ALIGN_EN
  logic center_mode = 1'b0;
`endif
  logic [CH-1:0] pwm_out;
  logic period_start, update_pending, running;
  int errors = 0, checks = 0;
  int mode, e, ap, aps;
  bit ac;
  int sh [CH];
  int ad [CH];
  logic [CH-1:0] x_pwm;
  logic x_ps;
  pwm_multichannel #(.CHANNELS(CH), .WIDTH(W), .PRESCALE_W(PW)) dut (
    .SLK(clk),
    .RST(rst),
    .enable(enable),
    .period(period),
    .prescale(prescale),
`ifdef PWM_CENTER_ALIGN_EN
    .center_mode(center_mode),
`endif
    .wr_valid(wr_valid),
    .wr_ch(wr_ch),
    .wr_duty(wr_duty),
    .pwm_out(pwm_out),
    .period_start(period_start),
    .update_pending(update_pending),
    .running(running)
  );
  always #5 clk = ~clk;
  function automatic int peff();
    return (ap == 0) ? 1 : ap;
  endfunction
  function automatic int plen();
    return peff() * (aps + 1) * (ac ? 2 : 1);
  endfunction
  // counter value implied by the elapsed cycles since the last boundary
  function automatic int cnt_at(input int el);
    int k = el / (aps + 1);
    if (ac) return (k < peff()) ? k : 2 * peff() - 1 - k;
    return k;
  endfunction
  task automatic model_reset();
    mode = 0; e = 0; ap = 0; aps = 0; ac = 1'b0;
    for (int i = 0; i < CH; i++) begin
      sh[i] = 0;
      ad[i] = 0;
    end
    x_pwm = '0; x_ps = 1'b0;
  endtask
  task automatic model_edge();
    logic [CH-1:0] nx = '0;
    bit ld = 1'b0;
    if (rst) begin
      model_reset();
      return;
    end
    if (mode == 0) begin
      ld = enable;
      mode = enable ? 1 : 0;
    end else begin
      bit last = (e == plen() - 1);
      for (int i = 0; i < CH; i++) nx[i] = (ap != 0) && (cnt_at(e) < ad[i]);
      if (last) begin
        ld = enable;
        if (!enable) nx = '0;
      end else e++;
      mode = (last && !enable) ? 0 : enable ? 1 : 2;
    end
    x_pwm = nx;
    x_ps = ld;
    if (ld) begin
      e = 0;
      ap = int'(period);
      aps = int'(prescale);
`ifdef PWM_CENTER_ALIGN_EN
      ac = center_mode;
`endif
      for (int i = 0; i < CH; i++) ad[i] = sh[i];
    end
    if (wr_valid && int'(wr_ch) < CH) sh[int'(wr_ch)] = int'(wr_duty);
  endtask
  task automatic check_all();
    bit pend = 1'b0;
    for (int i = 0; i < CH; i++) pend = pend | (sh[i] != ad[i]);
    checks += 4;
    assert (pwm_out === x_pwm) else begin errors++; $error("FAIL pwm_out got %b exp %b t=%0t", pwm_out, x_pwm, $time); end
    assert (period_start === x_ps) else begin errors++; $error("FAIL period_start got %b exp %b t=%0t", period_start, x_ps, $time); end
    assert (running === (mode != 0)) else begin errors++; $error("FAIL running got %b exp %b t=%0t", running, mode != 0, $time); end
    assert (update_pending === pend) else begin errors++; $error("FAIL update_pending got %b exp %b t=%0t", update_pending, pend, $time); end
  endtask
  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask
  task automatic write_duty(input int ch, input int d);
    wr_valid = 1'b1;
    wr_ch = CW'(ch);
    wr_duty = W'(d);
    cyc();
    wr_valid = 1'b0;
  endtask
  task automatic wait_ps(input int budget);
    int n = 0;
    while (period_start !== 1'b1 && n < budget) begin
      cyc();
      n++;
    end
    checks++;
    assert (period_start === 1'b1) else begin errors++; $error("FAIL wait_period_start timeout got %b exp 1 after %0d", period_start, n); end
  endtask
  initial begin
    int hi, nps, n;
    model_reset();
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    period = 8'd10;
    prescale = '0;
    write_duty(0, 3);
    write_duty(1, 5);
    write_duty(2, 0);
    write_duty(3, 12);
    write_duty(4, 10);
    write_duty(6, 9);
    enable = 1'b1;
    cyc();
    hi = 0;
    nps = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      hi += int'(pwm_out[0]);
      nps += int'(period_start);
    end
    checks += 2;
    assert (hi === 3) else begin errors++; $error("FAIL ch0_high_cycles got %0d exp 3", hi); end
    assert (nps === 1) else begin errors++; $error("FAIL period_start_count got %0d exp 1", nps); end
    repeat (3) cyc();
    write_duty(1, 8);
    repeat (25) cyc();
    prescale = 8'd1;
    cyc();
    wait_ps(40);
    repeat (8) cyc();
    enable = 1'b0;
    n = 0;
    while (running && n < 60) begin
      cyc();
      n++;
    end
    checks++;
    assert (n === 12) else begin errors++; $error("FAIL drain_cycles got %0d exp 12", n); end
    enable = 1'b1;
    cyc();
    wait_ps(10);
    repeat (6) cyc();
    enable = 1'b0;
    repeat (4) cyc();
    enable = 1'b1;
    n = 0;
    do begin
      cyc();
      n++;
    end while (period_start !== 1'b1 && n < 40);
    checks++;
    assert (n === 10) else begin errors++; $error("FAIL resume_next_start got %0d exp 10", n); end
    period = '0;
    prescale = 8'd2;
    repeat (12) cyc();
    for (int k = 0; k < 500; k++) begin
      if ($urandom_range(0, 15) == 0) enable = ~enable;
      if ($urandom_range(0, 3) == 0) begin
        wr_valid = 1'b1;
        wr_ch = CW'($urandom_range(0, 7));
        wr_duty = W'($urandom_range(0, 18));
      end else wr_valid = 1'b0;
      if ($urandom_range(0, 9) == 0) begin
        period = W'($urandom_range(0, 14));
        prescale = PW'($urandom_range(0, 3));
`ifdef PWM_CENTER_ALIGN_EN
        center_mode = 1'($urandom_range(0, 1));
`endif
      end
      cyc();
    end
    wr_valid = 1'b0;
    enable = 1'b1;
    period = 8'd10;
    prescale = '0;
`ifdef PWM_CENTER_ALIGN_EN
    center_mode = 1'b0;
`endif
    write_duty(3, 12);
    cyc();
    wait_ps(200);
    cyc();
    wait_ps(200);
    repeat (3) cyc();
    checks++;
    assert (pwm_out[3] === 1'b1) else begin errors++; $error("FAIL pre_reset_ch3 got %b exp 1", pwm_out[3]); end
    #1 rst = 1'b1;
    #1;
    checks += 3;
    assert (pwm_out === '0) else begin errors++; $error("FAIL async_reset_pwm got %b exp 0", pwm_out); end
    assert (running === 1'b0) else begin errors++; $error("FAIL async_reset_running got %b exp 0", running); end
    assert (update_pending === 1'b0) else begin errors++; $error("FAIL async_reset_pending got %b exp 0", update_pending); end
    model_reset();
    cyc();
    rst = 1'b0;
    repeat (25) cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
